axi_stream_frame_source: RTL and testbench

- AXI4-Stream master that generates video-style frames (h_size x v_size beats) into downstream buffers and processing cores, e.g. the 32-entry short FIFO.
- Marks start-of-frame on o_tuser and end-of-line on o_tlast.
- Fully honours o_tready back-pressure.
- Used as a pattern source for bring-up and as the stimulus end of the user processing core pipeline.

---
 rtl/axi_stream_frame_source.sv | 218 +++++++++++++++++++++
 tb/tb_axi_stream_frame_source.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_frame_source.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_frame_source
// Brief    : AXI4-Stream master generating h_size x v_size frames of pattern
//            data. o_tuser marks start-of-frame and o_tlast marks end-of-line.
//            Optional valid throttling is enabled by defining the macro
//            AXIS_FRAME_SRC_THROTTLE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axi_stream_frame_source #(
    parameter int WIDTH = 32,
    parameter int DIM_W = 12
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             continuous,
    input  logic [DIM_W-1:0] h_size,
    input  logic [DIM_W-1:0] v_size,
    input  logic [1:0]       pattern_sel,
    input  logic [WIDTH-1:0] fill_value,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             o_tlast,
    output logic             o_tuser,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_count
);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_SEND      = 2'd1;
    localparam logic [1:0] c_ST_FRAME_END = 2'd2;

    localparam logic [1:0] c_PAT_COUNTER = 2'd0;
    localparam logic [1:0] c_PAT_X       = 2'd1;
    localparam logic [1:0] c_PAT_Y       = 2'd2;

    logic [1:0]       r_state;
    logic [DIM_W-1:0] r_x;
    logic [DIM_W-1:0] r_y;
    logic [WIDTH-1:0] r_beat;
    logic [DIM_W-1:0] r_h_size;
    logic [DIM_W-1:0] r_v_size;
    logic             r_continuous;
    logic [1:0]       r_pattern;
    logic [WIDTH-1:0] r_fill;
    logic [WIDTH-1:0] r_tdata;
    logic             r_tvalid;
    logic             r_tlast;
    logic             r_tuser;
    logic             r_busy;
    logic             r_frame_done;
    logic [15:0]      r_frame_count;

    logic             w_handshake;
    logic             w_x_last;
    logic             w_y_last;
    logic [DIM_W-1:0] w_x_next;
    logic [DIM_W-1:0] w_y_next;
    logic [WIDTH-1:0] w_beat_next;
    logic             w_gate;
    logic             w_start_ok;

    // Data word for a beat at (x,y), zero-extended to the stream width
    function automatic logic [WIDTH-1:0] f_data(
        input logic [1:0]       pat,
        input logic [DIM_W-1:0] x,
        input logic [DIM_W-1:0] y,
        input logic [WIDTH-1:0] beat,
        input logic [WIDTH-1:0] fill
    );
        logic [WIDTH-1:0] v_d;
        case (pat)
            c_PAT_COUNTER: v_d = beat;
            c_PAT_X:       v_d = WIDTH'(x);
            c_PAT_Y:       v_d = WIDTH'(y);
            default:       v_d = fill;
        endcase
        return v_d;
    endfunction

    // Position bookkeeping for the beat currently owned by the counters
    always_comb begin
        w_handshake = r_tvalid & o_tready;
        w_x_last    = (r_x == (r_h_size - DIM_W'(1)));
        w_y_last    = (r_y == (r_v_size - DIM_W'(1)));
        w_x_next    = w_x_last ? '0 : (r_x + DIM_W'(1));
        w_y_next    = w_x_last ? (r_y + DIM_W'(1)) : r_y;
        w_beat_next = r_beat + WIDTH'(1);
        w_start_ok  = start && (h_size != '0) && (v_size != '0);
    end

`ifdef AXIS_FRAME_SRC_THROTTLE_EN
    logic [15:0] r_lfsr;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) pacing valid assertion
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    // Throttle only gates a new assertion; a pending beat is never withdrawn
    assign w_gate = (r_lfsr[1:0] != 2'b00);
`else
    assign w_gate = 1'b1;
`endif

    // Frame sequencer: counters hold the position of the beat being (or about
    // to be) presented; every output is registered so o_tready never reaches
    // an output combinationally.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            r_state       <= c_ST_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_beat        <= '0;
            r_h_size      <= '0;
            r_v_size      <= '0;
            r_continuous  <= 1'b0;
            r_pattern     <= 2'b00;
            r_fill        <= '0;
            r_tdata       <= '0;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_tuser       <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // Zero-sized requests are silently ignored
                    if (w_start_ok) begin
                        r_h_size     <= h_size;
                        r_v_size     <= v_size;
                        r_continuous <= continuous;
                        r_pattern    <= pattern_sel;
                        r_fill       <= fill_value;
                        r_x          <= '0;
                        r_y          <= '0;
                        r_beat       <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= c_ST_SEND;
                    end
                end

                c_ST_SEND: begin
                    if (w_handshake) begin
                        r_beat <= w_beat_next;
                        if (w_x_last && w_y_last) begin
                            r_tvalid      <= 1'b0;
                            r_x           <= '0;
                            r_frame_done  <= 1'b1;
                            r_frame_count <= r_frame_count + 16'd1;
                            r_state       <= c_ST_FRAME_END;
                        end else begin
                            r_x <= w_x_next;
                            r_y <= w_y_next;
                            // Back-to-back beat straight after the handshake
                            if (w_gate) begin
                                r_tvalid <= 1'b1;
                                r_tdata  <= f_data(r_pattern, w_x_next, w_y_next, w_beat_next, r_fill);
                                r_tlast  <= (w_x_next == (r_h_size - DIM_W'(1)));
                                r_tuser  <= (w_x_next == '0) && (w_y_next == '0);
                            end else begin
                                r_tvalid <= 1'b0;
                            end
                        end
                    end else if (!r_tvalid && w_gate) begin
                        // Present the beat held in the counters (frame start
                        // or after a throttle gap)
                        r_tvalid <= 1'b1;
                        r_tdata  <= f_data(r_pattern, r_x, r_y, r_beat, r_fill);
                        r_tlast  <= (r_x == (r_h_size - DIM_W'(1)));
                        r_tuser  <= (r_x == '0) && (r_y == '0);
                    end
                end

                c_ST_FRAME_END: begin
                    r_x    <= '0;
                    r_y    <= '0;
                    r_beat <= '0;
                    // stop is only honoured here so a frame is never truncated
                    if (r_continuous && !stop) begin
                        r_state <= c_ST_SEND;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_tvalid <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign o_tdata     = r_tdata;
    assign o_tvalid    = r_tvalid;
    assign o_tlast     = r_tlast;
    assign o_tuser     = r_tuser;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_frame_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_stream_frame_source
// Brief    : Self-checking bench for axi_stream_frame_source. Expected beats
//            are queued when a frame is requested and compared when accepted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_stream_frame_source;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        u;
    } beat_t;

    logic        clk;
    logic        resetn;
    logic        clear;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [11:0] h_size;
    logic [11:0] v_size;
    logic [1:0]  pattern_sel;
    logic [31:0] fill_value;
    logic [31:0] o_tdata;
    logic        o_tvalid;
    logic        o_tready;
    logic        o_tlast;
    logic        o_tuser;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;

    int          checks;
    int          errors;
    beat_t       sb[$];
    int          hs_times[$];
    int          hs_count;
    int          fd_count;
    int          cyc;
    int          rmode;
    logic        seen_valid;
    logic        p_v;
    logic        p_r;
    logic        p_ok;
    logic [31:0] p_d;
    logic        p_l;
    logic        p_u;

    axi_stream_frame_source #(
        .WIDTH (32),
        .DIM_W (12)
    ) u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .clear       (clear),
        .start       (start),
        .stop        (stop),
        .continuous  (continuous),
        .h_size      (h_size),
        .v_size      (v_size),
        .pattern_sel (pattern_sel),
        .fill_value  (fill_value),
        .o_tdata     (o_tdata),
        .o_tvalid    (o_tvalid),
        .o_tready    (o_tready),
        .o_tlast     (o_tlast),
        .o_tuser     (o_tuser),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = pattern 1,0,0,1, 2 = held low
    always @(posedge clk) begin
        cyc++;
        #2;
        case (rmode)
            0:       o_tready = 1'b1;
            1:       o_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: o_tready = 1'b0;
        endcase
    end

    // Monitor: scoreboard pop on accepted beats plus stall-stability checks
    always @(negedge clk) begin
        if (resetn && !clear && o_tvalid && o_tready) begin
            check("beat_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                beat_t e;
                e = sb.pop_front();
                check("beat_data", 64'(o_tdata), 64'(e.d));
                check("beat_last", 64'(o_tlast), 64'(e.l));
                check("beat_user", 64'(o_tuser), 64'(e.u));
            end
            hs_times.push_back(cyc);
            hs_count++;
        end
        if (p_v && !p_r && p_ok) begin
            check("stall_valid", 64'(o_tvalid), 64'd1);
            check("stall_data", 64'(o_tdata), 64'(p_d));
            check("stall_last", 64'(o_tlast), 64'(p_l));
            check("stall_user", 64'(o_tuser), 64'(p_u));
        end
        if (frame_done) fd_count++;
        if (o_tvalid) seen_valid = 1'b1;
        p_v  = o_tvalid;
        p_r  = o_tready;
        p_ok = resetn && !clear;
        p_d  = o_tdata;
        p_l  = o_tlast;
        p_u  = o_tuser;
    end

    task automatic push_frame(input int h, input int v, input logic [1:0] pat, input logic [31:0] fill);
        int n;
        n = 0;
        for (int y = 0; y < v; y++) begin
            for (int x = 0; x < h; x++) begin
                beat_t b;
                case (pat)
                    2'd0:    b.d = 32'(n);
                    2'd1:    b.d = 32'(x);
                    2'd2:    b.d = 32'(y);
                    default: b.d = fill;
                endcase
                b.l = (x == h - 1);
                b.u = (x == 0) && (y == 0);
                sb.push_back(b);
                n++;
            end
        end
    endtask

    task automatic start_frame(input int h, input int v, input logic [1:0] pat,
                               input logic cont, input logic [31:0] fill);
        hs_count = 0;
        hs_times.delete();
        h_size      = 12'(h);
        v_size      = 12'(v);
        pattern_sel = pat;
        continuous  = cont;
        fill_value  = fill;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        h_size      = 12'd7;
        v_size      = 12'd7;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        int fd0;
        int n;
        checks = 0; errors = 0; hs_count = 0; fd_count = 0; cyc = 0; rmode = 0;
        seen_valid = 1'b0;
        p_v = 1'b0; p_r = 1'b0; p_ok = 1'b0; p_d = '0; p_l = 1'b0; p_u = 1'b0;
        o_tready = 1'b1;
        resetn = 1'b0; clear = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        h_size = '0; v_size = '0; pattern_sel = '0; fill_value = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(o_tvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tdata", 64'(o_tdata), 64'd0);
        check("rst_markers", 64'({o_tlast, o_tuser, frame_done}), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // 4x2 counter frame, always ready
        push_frame(4, 2, 2'd0, 32'd0);
        fd0 = fd_count;
        start_frame(4, 2, 2'd0, 1'b0, 32'd0);
        check("lat_busy", 64'(busy), 64'd1);
        check("lat_valid_first_edge", 64'(o_tvalid), 64'd0);
        @(posedge clk); #1;
`ifndef AXIS_FRAME_SRC_THROTTLE_EN
        check("lat_valid_second_edge", 64'(o_tvalid), 64'd1);
`endif
        wait_idle(100);
        check("f1_beats", 64'(hs_count), 64'd8);
        check("f1_sb_drained", 64'(sb.size()), 64'd0);
        check("f1_frame_done", 64'(fd_count - fd0), 64'd1);
        check("f1_frame_count", 64'(frame_count), 64'd1);
`ifndef AXIS_FRAME_SRC_THROTTLE_EN
        if (hs_times.size() == 8) check("f1_throughput", 64'(hs_times[7] - hs_times[0]), 64'd7);
`endif

        // Same frame under toggling back-pressure
        rmode = 1;
        push_frame(4, 2, 2'd0, 32'd0);
        start_frame(4, 2, 2'd0, 1'b0, 32'd0);
        wait_idle(200);
        rmode = 0;
        check("f2_beats", 64'(hs_count), 64'd8);
        check("f2_sb_drained", 64'(sb.size()), 64'd0);
        check("f2_frame_count", 64'(frame_count), 64'd2);

        // 1x1 fill frame
        push_frame(1, 1, 2'd3, 32'hDEADBEEF);
        start_frame(1, 1, 2'd3, 1'b0, 32'hDEADBEEF);
        wait_idle(50);
        check("f3_beats", 64'(hs_count), 64'd1);
        check("f3_sb_drained", 64'(sb.size()), 64'd0);
        check("f3_frame_count", 64'(frame_count), 64'd3);

        // Zero-size request is ignored
        fd0 = fd_count;
        seen_valid = 1'b0;
        start_frame(0, 2, 2'd0, 1'b0, 32'd0);
        check("zero_busy", 64'(busy), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("zero_no_valid", 64'(seen_valid), 64'd0);
        check("zero_no_done", 64'(fd_count - fd0), 64'd0);
        check("zero_frame_count", 64'(frame_count), 64'd3);

        // Continuous 3x3 x-pattern, stop raised during the second frame
        push_frame(3, 3, 2'd1, 32'd0);
        push_frame(3, 3, 2'd1, 32'd0);
        fd0 = fd_count;
        start_frame(3, 3, 2'd1, 1'b1, 32'd0);
        n = 0;
        while (fd_count == fd0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("cont_first_done", 64'(fd_count - fd0), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        stop = 1'b1;
        wait_idle(200);
        stop = 1'b0;
        continuous = 1'b0;
        check("cont_beats", 64'(hs_count), 64'd18);
        check("cont_sb_drained", 64'(sb.size()), 64'd0);
        check("cont_frames", 64'(fd_count - fd0), 64'd2);
        check("cont_frame_count", 64'(frame_count), 64'd5);
`ifndef AXIS_FRAME_SRC_THROTTLE_EN
        if (hs_times.size() == 18) check("cont_gap", 64'(hs_times[9] - hs_times[8]), 64'd3);
`endif

        // Reset mid-frame after six beats of a 4x4 counter frame
        push_frame(4, 2, 2'd0, 32'd0);
        sb = sb[0:5];
        start_frame(4, 4, 2'd0, 1'b0, 32'd0);
        n = 0;
        while (hs_count < 6 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_beats", 64'(hs_count), 64'd6);
        resetn = 1'b0;
        rmode  = 2;
        @(posedge clk); #1;
        check("mid_valid", 64'(o_tvalid), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_frame_count", 64'(frame_count), 64'd0);
        resetn = 1'b1;
        rmode  = 0;
        check("mid_sb_drained", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
        push_frame(2, 1, 2'd0, 32'd0);
        start_frame(2, 1, 2'd0, 1'b0, 32'd0);
        wait_idle(50);
        check("restart_beats", 64'(hs_count), 64'd2);
        check("restart_sb_drained", 64'(sb.size()), 64'd0);
        check("restart_frame_count", 64'(frame_count), 64'd1);

`ifdef AXIS_FRAME_SRC_THROTTLE_EN
        // Throttled 16x4 y-pattern: same beats, with valid gaps
        push_frame(16, 4, 2'd2, 32'd0);
        start_frame(16, 4, 2'd2, 1'b0, 32'd0);
        wait_idle(1000);
        check("thr_beats", 64'(hs_count), 64'd64);
        check("thr_sb_drained", 64'(sb.size()), 64'd0);
        if (hs_times.size() == 64) check("thr_gaps", 64'((hs_times[63] - hs_times[0]) > 63), 64'd1);
`endif

        // Soft clear while a beat is stalled
        rmode = 2;
        start_frame(4, 2, 2'd3, 1'b0, 32'h5A5A5A5A);
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr_valid", 64'(o_tvalid), 64'd0);
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_frame_count", 64'(frame_count), 64'd0);
        rmode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("clr_no_beats", 64'(hs_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
